riscv_hwloop_seq: RTL and testbench

Hardware-loop sequencer for the ID stage. It owns the per-loop start, end and count registers for N_LOOPS loops and accepts setup writes from the decoder and CSR path. Each cycle it compares the fetched PC against every armed end address, picks one winning loop by priority, and issues the jump and target. It tracks the in-flight counter decrement so back-to-back loop ends never over-iterate.

---
 rtl/riscv_hwloop_seq_if.sv | 40 ++++
 rtl/riscv_hwloop_seq.sv | 106 ++++++++++
 tb/tb_riscv_hwloop_seq.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_hwloop_seq_if.sv
// riscv_hwloop_seq_if: bus between the ID stage and the hardware-loop sequencer.
// Macro HWLP_PERF_CNT_EN adds the jump-counter signals.
interface riscv_hwloop_seq_if #(
    parameter int N_LOOPS   = 2,
    parameter int LOOP_ID_W = 1
);
    logic [31:0]           current_pc_i;
    logic                  pc_valid_i;
    logic                  stall_i;
    logic                  flush_i;
    logic [2:0]            we_i;
    logic [LOOP_ID_W-1:0]  regid_i;
    logic [31:0]           wdata_i;
    logic                  hwlp_jump_o;
    logic [31:0]           hwlp_targ_addr_o;
    logic [N_LOOPS-1:0]    active_o;
    logic [32*N_LOOPS-1:0] start_rdata_o;
    logic [32*N_LOOPS-1:0] end_rdata_o;
    logic [32*N_LOOPS-1:0] cnt_rdata_o;
`ifdef HWLP_PERF_CNT_EN
    logic                  perf_clr_i;
    logic [31:0]           hwlp_jumps_o;
`endif

    modport master (
`ifdef HWLP_PERF_CNT_EN
        output perf_clr_i, input hwlp_jumps_o,
`endif
        output current_pc_i, pc_valid_i, stall_i, flush_i, we_i, regid_i, wdata_i,
        input  hwlp_jump_o, hwlp_targ_addr_o, active_o, start_rdata_o, end_rdata_o, cnt_rdata_o
    );

    modport slave (
`ifdef HWLP_PERF_CNT_EN
        input perf_clr_i, output hwlp_jumps_o,
`endif
        input  current_pc_i, pc_valid_i, stall_i, flush_i, we_i, regid_i, wdata_i,
        output hwlp_jump_o, hwlp_targ_addr_o, active_o, start_rdata_o, end_rdata_o, cnt_rdata_o
    );
endinterface

// File: rtl/riscv_hwloop_seq.sv
// riscv_hwloop_seq: ID-stage hardware-loop sequencer with priority end-PC match and in-flight decrement tracking.
// Macro HWLP_PERF_CNT_EN adds a committed-jump performance counter.
module riscv_hwloop_seq #(
    parameter int N_LOOPS   = 2,
    parameter int LOOP_ID_W = (N_LOOPS > 1) ? $clog2(N_LOOPS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    riscv_hwloop_seq_if.slave      bus
);
    logic [31:0]          r_start [N_LOOPS];
    logic [31:0]          r_end   [N_LOOPS];
    logic [31:0]          r_cnt   [N_LOOPS];
    logic                 r_pend_vld;
    logic [LOOP_ID_W-1:0] r_pend_id;

    logic [31:0]          w_eff   [N_LOOPS];
    logic [N_LOOPS-1:0]   w_match;
    logic                 w_win_vld;
    logic [LOOP_ID_W-1:0] w_win_id;
    logic [31:0]          w_win_eff;
    logic [31:0]          w_win_start;
    logic                 w_jump;
    logic                 w_issue;
    logic                 w_cnt_hit;

    // eff subtracts the decrement still in flight so back-to-back ends never over-iterate
    always_comb begin
        for (int i = 0; i < N_LOOPS; i++) begin
            w_eff[i]   = r_cnt[i] - {31'd0, r_pend_vld && r_pend_id == LOOP_ID_W'(i)};
            w_match[i] = bus.pc_valid_i && bus.current_pc_i == r_end[i] && w_eff[i] != 32'd0;
        end
    end

    always_comb begin
        w_win_vld   = 1'b0;
        w_win_id    = '0;
        w_win_eff   = '0;
        w_win_start = '0;
        for (int i = N_LOOPS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_win_vld   = 1'b1;
                w_win_id    = LOOP_ID_W'(i);
                w_win_eff   = w_eff[i];
                w_win_start = r_start[i];
            end
        end
    end

    assign w_jump    = w_win_vld && w_win_eff > 32'd1;
    assign w_issue   = w_win_vld && !bus.stall_i && !bus.flush_i;
    assign w_cnt_hit = bus.we_i[2] && bus.regid_i == w_win_id;

    assign bus.hwlp_jump_o      = w_jump;
    assign bus.hwlp_targ_addr_o = w_jump ? w_win_start : 32'd0;

    for (genvar g = 0; g < N_LOOPS; g++) begin : g_rd
        assign bus.active_o[g]               = |w_eff[g];
        assign bus.start_rdata_o[32*g +: 32] = r_start[g];
        assign bus.end_rdata_o[32*g +: 32]   = r_end[g];
        assign bus.cnt_rdata_o[32*g +: 32]   = r_cnt[g];
    end

    // a count write to the winning loop supersedes the decrement issued alongside it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_vld <= 1'b0;
            r_pend_id  <= '0;
        end else begin
            r_pend_vld <= w_issue && !w_cnt_hit;
            r_pend_id  <= w_issue ? w_win_id : r_pend_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_LOOPS; i++) begin
                r_start[i] <= '0;
                r_end[i]   <= '0;
                r_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_LOOPS; i++) begin
                if (bus.we_i[0] && bus.regid_i == LOOP_ID_W'(i)) r_start[i] <= bus.wdata_i;
                if (bus.we_i[1] && bus.regid_i == LOOP_ID_W'(i)) r_end[i] <= bus.wdata_i;
                if (bus.we_i[2] && bus.regid_i == LOOP_ID_W'(i))
                    r_cnt[i] <= bus.wdata_i;
                else if (r_pend_vld && r_pend_id == LOOP_ID_W'(i) && !bus.flush_i)
                    r_cnt[i] <= r_cnt[i] - 32'd1;
            end
        end
    end

`ifdef HWLP_PERF_CNT_EN
    logic [31:0] r_jumps;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_jumps <= '0;
        else if (bus.perf_clr_i)
            r_jumps <= '0;
        else if (w_issue && w_jump)
            r_jumps <= r_jumps + 32'd1;
    end
    assign bus.hwlp_jumps_o = r_jumps;
`endif
endmodule

// File: tb/tb_riscv_hwloop_seq.sv
// tb_riscv_hwloop_seq: directed self-checking bench for the hardware-loop sequencer.
module tb_riscv_hwloop_seq;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    riscv_hwloop_seq_if #(.N_LOOPS(2), .LOOP_ID_W(1)) u_if ();

    riscv_hwloop_seq #(.N_LOOPS(2), .LOOP_ID_W(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] cnt(input int i);
        return u_if.cnt_rdata_o[32*i +: 32];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] we, input int id, input logic [31:0] d);
        u_if.we_i    = we;
        u_if.regid_i = id[0];
        u_if.wdata_i = d;
        cyc();
        u_if.we_i    = 3'b000;
    endtask

    task automatic setup(input int id, input logic [31:0] s, input logic [31:0] e, input logic [31:0] c);
        wr(3'b001, id, s);
        wr(3'b010, id, e);
        wr(3'b100, id, c);
    endtask

    task automatic test_reset();
        #2;
        n_tests++; if (u_if.hwlp_jump_o !== 1'b0) begin n_fail++; $display("FAIL reset_jump got %0b want 0", u_if.hwlp_jump_o); end
        n_tests++; if (u_if.hwlp_targ_addr_o !== 32'd0) begin n_fail++; $display("FAIL reset_targ got %h want 0", u_if.hwlp_targ_addr_o); end
        n_tests++; if (u_if.active_o !== 2'b00) begin n_fail++; $display("FAIL reset_active got %b want 00", u_if.active_o); end
        n_tests++; if (u_if.start_rdata_o !== 64'd0 || u_if.end_rdata_o !== 64'd0) begin n_fail++; $display("FAIL reset_startend got %h/%h want 0", u_if.start_rdata_o, u_if.end_rdata_o); end
        n_tests++; if (u_if.cnt_rdata_o !== 64'd0) begin n_fail++; $display("FAIL reset_cnt got %h want 0", u_if.cnt_rdata_o); end
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        setup(0, 32'h100, 32'h10C, 32'd3);
        n_tests++; if (u_if.active_o[0] !== 1'b1 || cnt(0) !== 32'd3) begin n_fail++; $display("FAIL basic_setup active %b cnt %0d want 1/3", u_if.active_o, cnt(0)); end
        for (int p = 0; p < 3; p++) begin
            u_if.current_pc_i = 32'h10C;
            u_if.pc_valid_i   = 1'b1;
            #1;
            n_tests++; if (u_if.hwlp_jump_o !== (p < 2)) begin n_fail++; $display("FAIL basic_jump pass%0d got %0b want %0b", p, u_if.hwlp_jump_o, p < 2); end
            n_tests++; if (u_if.hwlp_targ_addr_o !== (p < 2 ? 32'h100 : 32'h0)) begin n_fail++; $display("FAIL basic_targ pass%0d got %h", p, u_if.hwlp_targ_addr_o); end
            cyc();
            u_if.pc_valid_i = 1'b0;
            cyc();
            n_tests++; if (cnt(0) !== 32'(2 - p)) begin n_fail++; $display("FAIL basic_cnt pass%0d got %0d want %0d", p, cnt(0), 2 - p); end
        end
        n_tests++; if (u_if.active_o[0] !== 1'b0) begin n_fail++; $display("FAIL basic_active got %b want 0", u_if.active_o[0]); end
    endtask

    task automatic test_back_to_back();
        wr(3'b100, 0, 32'd2);
        u_if.current_pc_i = 32'h10C;
        u_if.pc_valid_i   = 1'b1;
        #1;
        n_tests++; if (u_if.hwlp_jump_o !== 1'b1) begin n_fail++; $display("FAIL b2b_first_jump got %0b want 1", u_if.hwlp_jump_o); end
        cyc();
        n_tests++; if (u_if.hwlp_jump_o !== 1'b0 || u_if.hwlp_targ_addr_o !== 32'd0) begin n_fail++; $display("FAIL b2b_second_nojump got %0b/%h want 0/0", u_if.hwlp_jump_o, u_if.hwlp_targ_addr_o); end
        cyc();
        u_if.pc_valid_i = 1'b0;
        n_tests++; if (cnt(0) !== 32'd1) begin n_fail++; $display("FAIL b2b_mid_cnt got %0d want 1", cnt(0)); end
        cyc();
        n_tests++; if (cnt(0) !== 32'd0 || u_if.active_o[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_final cnt %0d active %b want 0/0", cnt(0), u_if.active_o[0]); end
    endtask

    task automatic test_nested();
        setup(0, 32'h110, 32'h120, 32'd2);
        setup(1, 32'h200, 32'h120, 32'd5);
        u_if.current_pc_i = 32'h120;
        u_if.pc_valid_i   = 1'b1;
        #1;
        n_tests++; if (u_if.hwlp_jump_o !== 1'b1 || u_if.hwlp_targ_addr_o !== 32'h110) begin n_fail++; $display("FAIL nested_inner got %0b/%h want 1/110", u_if.hwlp_jump_o, u_if.hwlp_targ_addr_o); end
        cyc(); u_if.pc_valid_i = 1'b0; cyc();
        n_tests++; if (cnt(0) !== 32'd1 || cnt(1) !== 32'd5) begin n_fail++; $display("FAIL nested_cnt got %0d/%0d want 1/5", cnt(0), cnt(1)); end
        u_if.pc_valid_i = 1'b1;
        #1;
        n_tests++; if (u_if.hwlp_jump_o !== 1'b0 || u_if.hwlp_targ_addr_o !== 32'd0) begin n_fail++; $display("FAIL nested_last got %0b/%h want 0/0", u_if.hwlp_jump_o, u_if.hwlp_targ_addr_o); end
        cyc(); u_if.pc_valid_i = 1'b0; cyc();
        u_if.pc_valid_i = 1'b1;
        #1;
        n_tests++; if (u_if.hwlp_jump_o !== 1'b1 || u_if.hwlp_targ_addr_o !== 32'h200) begin n_fail++; $display("FAIL nested_outer got %0b/%h want 1/200", u_if.hwlp_jump_o, u_if.hwlp_targ_addr_o); end
        cyc(); u_if.pc_valid_i = 1'b0; cyc();
        n_tests++; if (cnt(0) !== 32'd0 || cnt(1) !== 32'd4) begin n_fail++; $display("FAIL nested_cnt2 got %0d/%0d want 0/4", cnt(0), cnt(1)); end
    endtask

    task automatic test_stall();
        setup(0, 32'h100, 32'h10C, 32'd4);
        u_if.current_pc_i = 32'h10C;
        u_if.pc_valid_i   = 1'b1;
        u_if.stall_i      = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++; if (u_if.hwlp_jump_o !== 1'b1 || u_if.hwlp_targ_addr_o !== 32'h100) begin n_fail++; $display("FAIL stall_jump c%0d got %0b/%h want 1/100", c, u_if.hwlp_jump_o, u_if.hwlp_targ_addr_o); end
            cyc();
            n_tests++; if (cnt(0) !== 32'd4) begin n_fail++; $display("FAIL stall_cnt c%0d got %0d want 4", c, cnt(0)); end
        end
        u_if.stall_i = 1'b0;
        cyc();
        u_if.pc_valid_i = 1'b0;
        cyc();
        n_tests++; if (cnt(0) !== 32'd3) begin n_fail++; $display("FAIL stall_release_cnt got %0d want 3", cnt(0)); end
    endtask

    task automatic test_flush();
        u_if.pc_valid_i = 1'b1;
        cyc();
        u_if.pc_valid_i = 1'b0;
        u_if.flush_i    = 1'b1;
        cyc();
        u_if.flush_i = 1'b0;
        cyc();
        n_tests++; if (cnt(0) !== 32'd3) begin n_fail++; $display("FAIL flush_cancel_cnt got %0d want 3", cnt(0)); end
        u_if.pc_valid_i = 1'b1;
        u_if.flush_i    = 1'b1;
        #1;
        n_tests++; if (u_if.hwlp_jump_o !== 1'b1) begin n_fail++; $display("FAIL flush_jump_driven got %0b want 1", u_if.hwlp_jump_o); end
        cyc();
        u_if.pc_valid_i = 1'b0;
        u_if.flush_i    = 1'b0;
        cyc();
        n_tests++; if (cnt(0) !== 32'd3) begin n_fail++; $display("FAIL flush_noissue_cnt got %0d want 3", cnt(0)); end
        u_if.pc_valid_i = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++; if (u_if.hwlp_jump_o !== 1'b0 || u_if.hwlp_targ_addr_o !== 32'd0 || u_if.active_o !== 2'b00) begin n_fail++; $display("FAIL midreset_out got %0b/%h/%b want 0/0/00", u_if.hwlp_jump_o, u_if.hwlp_targ_addr_o, u_if.active_o); end
        n_tests++; if (u_if.cnt_rdata_o !== 64'd0 || u_if.start_rdata_o !== 64'd0 || u_if.end_rdata_o !== 64'd0) begin n_fail++; $display("FAIL midreset_regs got cnt %h start %h end %h want 0", u_if.cnt_rdata_o, u_if.start_rdata_o, u_if.end_rdata_o); end
        u_if.pc_valid_i = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_cnt_override();
        setup(0, 32'h100, 32'h10C, 32'd2);
        u_if.current_pc_i = 32'h10C;
        u_if.pc_valid_i   = 1'b1;
        u_if.we_i         = 3'b100;
        u_if.regid_i      = 1'b0;
        u_if.wdata_i      = 32'd7;
        #1;
        n_tests++; if (u_if.hwlp_jump_o !== 1'b1 || u_if.hwlp_targ_addr_o !== 32'h100) begin n_fail++; $display("FAIL ovr_oldvals got %0b/%h want 1/100", u_if.hwlp_jump_o, u_if.hwlp_targ_addr_o); end
        cyc();
        u_if.we_i       = 3'b000;
        u_if.pc_valid_i = 1'b0;
        n_tests++; if (cnt(0) !== 32'd7) begin n_fail++; $display("FAIL ovr_cnt got %0d want 7", cnt(0)); end
        cyc();
        n_tests++; if (cnt(0) !== 32'd7) begin n_fail++; $display("FAIL ovr_nopend got %0d want 7", cnt(0)); end
        wr(3'b100, 0, 32'd0);
        u_if.pc_valid_i = 1'b1;
        #1;
        n_tests++; if (u_if.hwlp_jump_o !== 1'b0 || u_if.active_o[0] !== 1'b0) begin n_fail++; $display("FAIL zero_cnt got jump %0b active %b want 0/0", u_if.hwlp_jump_o, u_if.active_o[0]); end
        cyc(); u_if.pc_valid_i = 1'b0; cyc();
        n_tests++; if (cnt(0) !== 32'd0) begin n_fail++; $display("FAIL zero_cnt_stays got %0d want 0", cnt(0)); end
        wr(3'b100, 0, 32'hFFFF_FFFF);
        u_if.pc_valid_i = 1'b1;
        #1;
        n_tests++; if (u_if.hwlp_jump_o !== 1'b1) begin n_fail++; $display("FAIL max_cnt_jump got %0b want 1", u_if.hwlp_jump_o); end
        cyc(); u_if.pc_valid_i = 1'b0; cyc();
        n_tests++; if (cnt(0) !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL max_cnt_dec got %h want fffffffe", cnt(0)); end
    endtask

`ifdef HWLP_PERF_CNT_EN
    task automatic test_perf();
        u_if.perf_clr_i = 1'b1;
        cyc();
        u_if.perf_clr_i = 1'b0;
        n_tests++; if (u_if.hwlp_jumps_o !== 32'd0) begin n_fail++; $display("FAIL perf_clr got %0d want 0", u_if.hwlp_jumps_o); end
        wr(3'b100, 0, 32'd3);
        for (int p = 0; p < 3; p++) begin
            u_if.current_pc_i = 32'h10C;
            u_if.pc_valid_i   = 1'b1;
            cyc();
            u_if.pc_valid_i = 1'b0;
            cyc();
        end
        n_tests++; if (u_if.hwlp_jumps_o !== 32'd2) begin n_fail++; $display("FAIL perf_total got %0d want 2", u_if.hwlp_jumps_o); end
        wr(3'b100, 0, 32'd3);
        u_if.pc_valid_i = 1'b1;
        u_if.perf_clr_i = 1'b1;
        cyc();
        u_if.pc_valid_i = 1'b0;
        u_if.perf_clr_i = 1'b0;
        n_tests++; if (u_if.hwlp_jumps_o !== 32'd0) begin n_fail++; $display("FAIL perf_clr_prio got %0d want 0", u_if.hwlp_jumps_o); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        n_tests           = 0;
        n_fail            = 0;
        rst_n             = 1'b0;
        u_if.current_pc_i = '0;
        u_if.pc_valid_i   = 1'b0;
        u_if.stall_i      = 1'b0;
        u_if.flush_i      = 1'b0;
        u_if.we_i         = 3'b000;
        u_if.regid_i      = '0;
        u_if.wdata_i      = '0;
`ifdef HWLP_PERF_CNT_EN
        u_if.perf_clr_i   = 1'b0;
`endif
        test_reset();
        test_basic();
        test_back_to_back();
        test_nested();
        test_stall();
        test_flush();
        test_cnt_override();
`ifdef HWLP_PERF_CNT_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
